// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - iterative HI/LO multiply/divide unit
// Build with HILO_MULDIV_DIV_EN defined to include the restoring divider.
module hilo_muldiv #(
   parameter int n = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [n-1:0] srca,
   input  logic [n-1:0] srcb,
   input  logic         hi_we,
   input  logic         lo_we,
   input  logic [n-1:0] wdata,
   output logic         busy,
   output logic         done,
   output logic         div_zero,
   output logic [n-1:0] hi,
   output logic [n-1:0] lo
);
   localparam int CW = $clog2(n + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*n-1:0] acc_q, acc_d;
   logic [n-1:0]   opnd_q, opnd_d;
   logic           neg_a_q, neg_a_d;
   logic           neg_b_q, neg_b_d;
   logic           skip_q, skip_d;
   logic           done_q, done_d;
   logic           dz_q, dz_d;
   logic [n-1:0]   hi_q, hi_d;
   logic [n-1:0]   lo_q, lo_d;

   logic           a_neg, b_neg;
   logic [n-1:0]   a_mag, b_mag;
   logic [n:0]     mul_sum;
   logic [2*n-1:0] prod_fix;
`ifdef HILO_MULDIV_DIV_EN
   logic           is_div_q, is_div_d;
   logic [n:0]     div_shift, div_diff;
`endif

   assign a_neg = op[0] & srca[n-1];
   assign b_neg = op[0] & srcb[n-1];
   assign a_mag = a_neg ? -srca : srca;
   assign b_mag = b_neg ? -srcb : srcb;

   // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
   assign mul_sum  = acc_q[0] ? ({1'b0, acc_q[2*n-1:n]} + {1'b0, opnd_q})
                              : {1'b0, acc_q[2*n-1:n]};
   assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
`ifdef HILO_MULDIV_DIV_EN
   assign div_shift = {acc_q[2*n-1:n], acc_q[n-1]};
   assign div_diff  = div_shift - {1'b0, opnd_q};
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      skip_d  = skip_q;
      done_d  = 1'b0;
      dz_d    = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
`ifdef HILO_MULDIV_DIV_EN
      is_div_d = is_div_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (start) begin
               neg_a_d = a_neg;
               neg_b_d = b_neg;
               cnt_d   = CW'(n);
               opnd_d  = op[1] ? b_mag : a_mag;
               acc_d   = {{n{1'b0}}, (op[1] ? a_mag : b_mag)};
`ifdef HILO_MULDIV_DIV_EN
               is_div_d = op[1];
               skip_d   = op[1] & (srcb == '0);
`else
               skip_d   = op[1];
`endif
               state_d = skip_d ? S_FIN : S_RUN;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - CW'(1);
            acc_d = {mul_sum, acc_q[n-1:1]};
`ifdef HILO_MULDIV_DIV_EN
            if (is_div_q) begin
               acc_d = div_diff[n] ? {div_shift[n-1:0], acc_q[n-2:0], 1'b0}
                                   : {div_diff[n-1:0], acc_q[n-2:0], 1'b1};
            end
`endif
            if (cnt_q == CW'(1)) state_d = S_FIN;
         end
         S_FIN: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
`ifdef HILO_MULDIV_DIV_EN
            dz_d = skip_q;
            if (!skip_q && is_div_q) begin
               lo_d = (neg_a_q ^ neg_b_q) ? -acc_q[n-1:0] : acc_q[n-1:0];
               hi_d = neg_a_q ? -acc_q[2*n-1:n] : acc_q[2*n-1:n];
            end else if (!skip_q) begin
               hi_d = prod_fix[2*n-1:n];
               lo_d = prod_fix[n-1:0];
            end
`else
            if (!skip_q) begin
               hi_d = prod_fix[2*n-1:n];
               lo_d = prod_fix[n-1:0];
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         skip_q   <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
`ifdef HILO_MULDIV_DIV_EN
         is_div_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         skip_q   <= skip_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
`ifdef HILO_MULDIV_DIV_EN
         is_div_q <= is_div_d;
`endif
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
endmodule
